mem_boot_loader: RTL

Parametrised program loader/dumper between a byte-stream source and the datapath's unified RAM. Holds the CPU in reset while it writes a program image word-by-word through the RAM's MOC (memory-operation-complete) handshake. Releases the CPU on a clean load, and can read back a configurable memory window as an output stream. This is the synthesizable replacement for simulation-only memory precharge and dump loops.

---
 rtl/mem_boot_loader_if.sv | 35 +++
 rtl/mem_boot_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_boot_loader_if.sv
// Load stream, dump stream and RAM bus of the boot loader.
// The master modport is the loader's side; slave is the environment's side.
interface mem_boot_loader_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 9
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_moc;

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_ready;

    modport master (
        input  in_valid, in_data, in_last, mem_rdata, mem_moc, out_ready,
        output in_ready, mem_addr, mem_wdata, mem_we, mem_re,
               out_valid, out_data, out_addr
    );

    modport slave (
        output in_valid, in_data, in_last, mem_rdata, mem_moc, out_ready,
        input  in_ready, mem_addr, mem_wdata, mem_we, mem_re,
               out_valid, out_data, out_addr
    );
endinterface

// File: rtl/mem_boot_loader.sv
// Program loader/dumper: writes a byte-stream image into RAM via the MOC handshake
// while holding the CPU in reset, and reads back a fixed window as a stream.
module mem_boot_loader #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned DUMP_LEN    = 250,
    parameter int unsigned MOC_TIMEOUT = 15
) (
    input  logic                clk_i,
    input  logic                clear_i,
    input  logic                start_load_i,
    input  logic                start_dump_i,
    mem_boot_loader_if.master   bus,
    output logic                cpu_clear_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output logic [ADDR_W:0]     load_count_o
);

    localparam int unsigned     TMO_W     = $clog2(MOC_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DUMP_LAST = ADDR_W'(DUMP_LEN - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(MOC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        L_WAIT,
        L_WR,
        D_RD,
        D_OUT,
        FLUSH
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     load_count_q, load_count_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                last_q, last_d;
    logic                error_q, error_d;
    logic                cpu_clear_q, cpu_clear_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_re_q, mem_re_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        load_count_d = load_count_q;
        tmo_d        = tmo_q;
        last_d       = last_q;
        error_d      = error_q;
        cpu_clear_d  = cpu_clear_q;
        done_d       = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        out_data_d   = out_data_q;
        out_addr_d   = out_addr_q;

        unique case (state_q)
            IDLE: begin
                if (start_load_i) begin
                    state_d      = L_WAIT;
                    ptr_d        = '0;
                    load_count_d = '0;
                    error_d      = 1'b0;
                    cpu_clear_d  = 1'b1;
                end else if (start_dump_i) begin
                    state_d     = D_RD;
                    ptr_d       = '0;
                    tmo_d       = '0;
                    error_d     = 1'b0;
                    cpu_clear_d = 1'b1;
                end
            end

            L_WAIT: begin
                if (bus.in_valid) begin
                    mem_wdata_d = bus.in_data;
                    last_d      = bus.in_last;
                    tmo_d       = '0;
                    state_d     = L_WR;
                end
            end

            L_WR: begin
                if (bus.mem_moc) begin
                    ptr_d        = ptr_q + ADDR_W'(1);
                    load_count_d = load_count_q + (ADDR_W + 1)'(1);
                    if (last_q) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        cpu_clear_d = error_q;
                    end else if (ptr_q == LAST_ADDR) begin
                        state_d = FLUSH;
                        error_d = 1'b1;
                    end else begin
                        state_d = L_WAIT;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            FLUSH: begin
                if (bus.in_valid && bus.in_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end

            D_RD: begin
                if (bus.mem_moc) begin
                    out_data_d = bus.mem_rdata;
                    out_addr_d = ptr_q;
                    state_d    = D_OUT;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            D_OUT: begin
                if (bus.out_ready) begin
                    if (ptr_q == DUMP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d   = ptr_q + ADDR_W'(1);
                        tmo_d   = '0;
                        state_d = D_RD;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Strobes and flags are decoded from the next state so they register
        // in the same cycle the FSM enters the state that owns them.
        in_ready_d  = (state_d == L_WAIT) || (state_d == FLUSH);
        mem_we_d    = (state_d == L_WR);
        mem_re_d    = (state_d == D_RD);
        out_valid_d = (state_d == D_OUT);
        busy_d      = (state_d != IDLE);
        mem_addr_d  = (mem_we_d || mem_re_d) ? ptr_d : mem_addr_q;
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            load_count_q <= '0;
            tmo_q        <= '0;
            last_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_clear_q  <= 1'b1;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            load_count_q <= load_count_d;
            tmo_q        <= tmo_d;
            last_q       <= last_d;
            error_q      <= error_d;
            cpu_clear_q  <= cpu_clear_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_addr_q   <= out_addr_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;

    assign cpu_clear_o  = cpu_clear_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign load_count_o = load_count_q;

endmodule
